// File: rtl/chaos_keystream_ctrl.sv
// chaos_keystream_ctrl: seeds and warms up a stepped chaotic map core,
// then serializes each {w,z,y,x} iterate onto a valid/ready keystream.
module chaos_keystream_ctrl #(
    parameter int W        = 32,
    parameter int CORE_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ap_start,
    output logic             ap_ready,
    output logic             ap_done,
    input  logic             abort,
    input  logic [4*W-1:0]   key_in,
    input  logic [CNT_W-1:0] warmup_n,
    input  logic [CNT_W-1:0] word_n,
    output logic             core_load,
    output logic [4*W-1:0]   core_seed,
    output logic             core_step,
    input  logic [4*W-1:0]   core_state,
    output logic [W-1:0]     ks_data,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic             ks_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WSTEP, S_WWAIT,
        S_STEP, S_WAIT, S_EMIT, S_DONE
    } state_t;

    localparam int LW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [LW-1:0]    LAT_LAST = LW'(CORE_LAT - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    state_t           state;
    state_t           warm_nxt;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] wnext;
    logic [LW-1:0]    lat;
    logic [1:0]       lane;
    logic [W-1:0]     buf_q [4];
    logic             lat_done;

    assign lat_done = (lat == LAT_LAST);

    // Where to go once a seed load or a warm-up iterate has completed
    always_comb begin
        wnext = wcnt;
        if (state == S_WWAIT) wnext = wcnt - ONE;
        warm_nxt = S_DONE;
        if (wnext != '0)
            warm_nxt = S_WSTEP;
        else if (rem != '0)
            warm_nxt = S_STEP;
    end

    // Sequencer FSM; every output is a register set on entry to its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ap_ready  <= 1'b1;
            ap_done   <= 1'b0;
            core_load <= 1'b0;
            core_step <= 1'b0;
            core_seed <= '0;
            ks_valid  <= 1'b0;
            ks_last   <= 1'b0;
            ks_data   <= '0;
            wcnt      <= '0;
            rem       <= '0;
            lat       <= '0;
            lane      <= '0;
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
        end else begin
            ap_done   <= 1'b0;
            core_load <= 1'b0;
            core_step <= 1'b0;
            if (abort && state != S_IDLE) begin
                state    <= S_IDLE;
                ap_ready <= 1'b1;
                ks_valid <= 1'b0;
                ks_last  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (ap_start && !abort) begin
                            core_seed <= key_in;
                            wcnt      <= warmup_n;
                            rem       <= word_n;
                            core_load <= 1'b1;
                            ap_ready  <= 1'b0;
                            state     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        state     <= warm_nxt;
                        core_step <= (warm_nxt != S_DONE);
                        ap_done   <= (warm_nxt == S_DONE);
                    end
                    S_WSTEP: begin
                        lat   <= '0;
                        state <= S_WWAIT;
                    end
                    S_WWAIT: begin
                        if (lat_done) begin
                            wcnt      <= wnext;
                            state     <= warm_nxt;
                            core_step <= (warm_nxt != S_DONE);
                            ap_done   <= (warm_nxt == S_DONE);
                        end else begin
                            lat <= lat + LW'(1);
                        end
                    end
                    S_STEP: begin
                        lat   <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (lat_done) begin
                            for (int i = 0; i < 4; i++)
                                buf_q[i] <= core_state[i*W +: W];
                            lane     <= '0;
                            ks_data  <= core_state[W-1:0];
                            ks_last  <= (rem == ONE);
                            ks_valid <= 1'b1;
                            state    <= S_EMIT;
                        end else begin
                            lat <= lat + LW'(1);
                        end
                    end
                    S_EMIT: begin
                        if (ks_ready) begin
                            rem  <= rem - ONE;
                            lane <= lane + 2'd1;
                            if (rem == ONE) begin
                                ks_valid <= 1'b0;
                                ks_last  <= 1'b0;
                                ap_done  <= 1'b1;
                                state    <= S_DONE;
                            end else if (lane == 2'd3) begin
                                ks_valid  <= 1'b0;
                                ks_last   <= 1'b0;
                                core_step <= 1'b1;
                                state     <= S_STEP;
                            end else begin
                                ks_data <= buf_q[lane + 2'd1];
                                ks_last <= (rem == TWO);
                            end
                        end
                    end
                    S_DONE: begin
                        ap_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
